// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// ---------------------------------------------------------------------------
// Central pipeline sequencer for the 5-stage RISC-V core.  It merges the
// load-use stall, EX-stage branch redirects, multi-cycle MDU waits and
// fault-detection events.  From these it drives the per-stage register
// enables, the per-stage bubble (flush) controls and the PC-select code.
// A fault starts a bounded replay from the faulting instruction.  Once the
// retry budget is used up, the core halts until a debug release arrives.
//
// Parameters
//   MAX_RETRY      replays allowed before HALT (1..15)
//   REPLAY_CYCLES  number of cycles spent in REPLAY (2..15)
//
// Ports
//   clk                 core clock
//   rst_n               asynchronous active-low reset
//   load_use_stall      ID needs the result of a load still in EX
//   branch_taken_ex     branch/jump in EX resolved taken
//   mdu_start_ex        multi-cycle MDU op occupies EX this cycle
//   mdu_done            MDU result valid this cycle
//   fault_detected      fault checker flags the instruction in MEM
//   retire_wb           instruction retired cleanly in WB
//   fault_clear         debug release from HALT
//   pc_en .. mem_wb_en  pipeline register enables
//   if_id_flush ..      insert a bubble into that pipeline register
//   pc_sel              00 PC+4, 01 branch target, 10 replay PC
//   replay_pc_capture   latch the MEM-stage PC into the replay register
//   mdu_abort           cancel the in-flight MDU op
//   state               00 RUN, 01 MDU_WAIT, 10 REPLAY, 11 HALT
//   retry_cnt           consecutive replays since the last clean retire
//   halted              high while in HALT
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int MAX_RETRY     = 3,
   parameter int REPLAY_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_use_stall,
   input  logic       branch_taken_ex,
   input  logic       mdu_start_ex,
   input  logic       mdu_done,
   input  logic       fault_detected,
   input  logic       retire_wb,
   input  logic       fault_clear,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_ex_en,
   output logic       ex_mem_en,
   output logic       mem_wb_en,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic [1:0] pc_sel,
   output logic       replay_pc_capture,
   output logic       mdu_abort,
   output logic [1:0] state,
   output logic [3:0] retry_cnt,
   output logic       halted
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MDU_WAIT = 2'b01,
      ST_REPLAY   = 2'b10,
      ST_HALT     = 2'b11
   } state_t;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_REPLAY = 2'b10;

   localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
   localparam logic [3:0] REPLAY_LOAD = 4'(REPLAY_CYCLES - 1);

   state_t     cur_state;
   state_t     nxt_state;
   logic [3:0] retry_q;
   logic [3:0] retry_d;
   logic [3:0] replay_q;
   logic [3:0] replay_d;

   // A fault is only acted on while instructions are really flowing.  In
   // REPLAY and HALT the pipeline is already being drained or frozen, so a
   // fault flag there carries no meaning.
   logic in_exec;
   logic take_fault;

   assign in_exec    = (cur_state == ST_RUN) || (cur_state == ST_MDU_WAIT);
   assign take_fault = in_exec && fault_detected;

   // State, retry budget and replay countdown are the only storage.  Reset
   // returns everything to a clean RUN state, even in the middle of a
   // replay or a halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state <= ST_RUN;
         retry_q   <= 4'd0;
         replay_q  <= 4'd0;
      end else begin
         cur_state <= nxt_state;
         retry_q   <= retry_d;
         replay_q  <= replay_d;
      end
   end

   // Next-state and control decode.  All control outputs depend on the
   // current state and on this cycle's inputs, so stalls, flushes and
   // redirects take effect in the same cycle as their cause.  Each state
   // starts from the free-running defaults and overrides only what it must.
   always_comb begin
      nxt_state         = cur_state;
      retry_d           = retry_q;
      replay_d          = replay_q;
      pc_en             = 1'b1;
      if_id_en          = 1'b1;
      id_ex_en          = 1'b1;
      ex_mem_en         = 1'b1;
      mem_wb_en         = 1'b1;
      if_id_flush       = 1'b0;
      id_ex_flush       = 1'b0;
      ex_mem_flush      = 1'b0;
      pc_sel            = PC_PLUS4;
      replay_pc_capture = 1'b0;
      mdu_abort         = 1'b0;

      if (take_fault) begin
         // Squash everything younger than the faulting op and keep the op
         // itself out of WB.  Fetch freezes so that the MEM-stage PC can be
         // captured and fetched again after the replay.  A fault outranks a
         // simultaneous branch, so no redirect to the branch target occurs.
         if_id_flush       = 1'b1;
         id_ex_flush       = 1'b1;
         ex_mem_flush      = 1'b1;
         mem_wb_en         = 1'b0;
         pc_en             = 1'b0;
         replay_pc_capture = 1'b1;
         mdu_abort         = (cur_state == ST_MDU_WAIT);
         if (retry_q < RETRY_LIMIT) begin
            retry_d   = retry_q + 4'd1;
            nxt_state = ST_REPLAY;
            replay_d  = REPLAY_LOAD;
         end else begin
            nxt_state = ST_HALT;
         end
      end else begin
         // A clean retire ends the run of consecutive faults.
         if (in_exec && retire_wb) begin
            retry_d = 4'd0;
         end

         case (cur_state)
            ST_RUN: begin
               if (branch_taken_ex) begin
                  pc_sel      = PC_BRANCH;
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (mdu_start_ex && !mdu_done) begin
                  // Hold the front end and feed bubbles into MEM while the
                  // MDU is busy.  An op that finishes in its first cycle
                  // needs no stall at all.
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
                  nxt_state    = ST_MDU_WAIT;
               end else if (load_use_stall) begin
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end

            ST_MDU_WAIT: begin
               // Branch and load-use requests are stale while EX is held,
               // so only completion of the MDU op matters here.
               if (mdu_done) begin
                  nxt_state = ST_RUN;
               end else begin
                  pc_en        = 1'b0;
                  if_id_en     = 1'b0;
                  id_ex_en     = 1'b0;
                  ex_mem_flush = 1'b1;
               end
            end

            ST_REPLAY: begin
               // Drain the pipe with bubbles.  On the last cycle, fetch
               // restarts from the captured replay PC.
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               ex_mem_flush = 1'b1;
               mem_wb_en    = 1'b0;
               pc_en        = 1'b0;
               if (replay_q == 4'd0) begin
                  pc_en     = 1'b1;
                  pc_sel    = PC_REPLAY;
                  nxt_state = ST_RUN;
               end else begin
                  replay_d = replay_q - 4'd1;
               end
            end

            ST_HALT: begin
               // Freeze every register.  Only a debug release brings the
               // core back, and it does so through a fresh replay with a
               // full retry budget.
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               mem_wb_en = 1'b0;
               if (fault_clear) begin
                  retry_d   = 4'd0;
                  nxt_state = ST_REPLAY;
                  replay_d  = REPLAY_LOAD;
               end
            end

            default: begin
               nxt_state = ST_RUN;
            end
         endcase
      end

      // While reset is held, the pipeline registers are frozen and filled
      // with bubbles.  Pulse outputs stay low.
      if (!rst_n) begin
         pc_en             = 1'b0;
         if_id_en          = 1'b0;
         id_ex_en          = 1'b0;
         ex_mem_en         = 1'b0;
         mem_wb_en         = 1'b0;
         if_id_flush       = 1'b1;
         id_ex_flush       = 1'b1;
         ex_mem_flush      = 1'b1;
         pc_sel            = PC_PLUS4;
         replay_pc_capture = 1'b0;
         mdu_abort         = 1'b0;
      end
   end

   assign state     = cur_state;
   assign retry_cnt = retry_q;
   assign halted    = (cur_state == ST_HALT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// ---------------------------------------------------------------------------
// Directed scoreboard bench for pipe_ctrl (MAX_RETRY 3, REPLAY_CYCLES 2).
// Each stimulus vector drives the inputs just after a rising edge and
// pushes the hand-computed output word for that cycle into a queue.  A
// separate monitor pops the queue on every falling edge and compares it
// against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_use_stall = 1'b0;
   logic       branch_taken_ex = 1'b0;
   logic       mdu_start_ex = 1'b0;
   logic       mdu_done = 1'b0;
   logic       fault_detected = 1'b0;
   logic       retire_wb = 1'b0;
   logic       fault_clear = 1'b0;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic       if_id_flush, id_ex_flush, ex_mem_flush;
   logic [1:0] pc_sel;
   logic       replay_pc_capture, mdu_abort;
   logic [1:0] state;
   logic [3:0] retry_cnt;
   logic       halted;

   pipe_ctrl #(.MAX_RETRY(3), .REPLAY_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_use_stall(load_use_stall), .branch_taken_ex(branch_taken_ex),
      .mdu_start_ex(mdu_start_ex), .mdu_done(mdu_done),
      .fault_detected(fault_detected), .retire_wb(retire_wb),
      .fault_clear(fault_clear),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
      .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .pc_sel(pc_sel),
      .replay_pc_capture(replay_pc_capture), .mdu_abort(mdu_abort),
      .state(state), .retry_cnt(retry_cnt), .halted(halted)
   );

   always #5 clk = ~clk;

   // Input word: {load_use, branch, mdu_start, mdu_done, fault, retire, clear}
   localparam logic [6:0] I_NONE = 7'b0000000;
   localparam logic [6:0] I_LU   = 7'b1000000;
   localparam logic [6:0] I_BR   = 7'b0100000;
   localparam logic [6:0] I_MS   = 7'b0010000;
   localparam logic [6:0] I_MD   = 7'b0001000;
   localparam logic [6:0] I_FLT  = 7'b0000100;
   localparam logic [6:0] I_RET  = 7'b0000010;
   localparam logic [6:0] I_CLR  = 7'b0000001;

   // Enables {pc, if_id, id_ex, ex_mem, mem_wb}; flushes {if_id, id_ex, ex_mem}
   localparam logic [4:0] EN_ALL   = 5'b11111;
   localparam logic [4:0] EN_NONE  = 5'b00000;
   localparam logic [4:0] EN_LU    = 5'b00111;
   localparam logic [4:0] EN_MDU   = 5'b00011;
   localparam logic [4:0] EN_FLT   = 5'b01110;
   localparam logic [4:0] EN_RPFIN = 5'b11110;
   localparam logic [2:0] FL_NONE  = 3'b000;
   localparam logic [2:0] FL_ALL   = 3'b111;

   typedef struct {
      string       name;
      logic [18:0] exp;
   } expect_t;

   expect_t sb_q[$];
   int      vectors_applied = 0;
   int      miscompares = 0;

   function automatic logic [18:0] mk(logic [4:0] en, logic [2:0] fl,
                                      logic [1:0] sel, logic cap, logic abrt,
                                      logic [1:0] st, logic [3:0] rc,
                                      logic halt);
      return {en, fl, sel, cap, abrt, st, rc, halt};
   endfunction

   function automatic logic [18:0] actual_word();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
              if_id_flush, id_ex_flush, ex_mem_flush, pc_sel,
              replay_pc_capture, mdu_abort, state, retry_cnt, halted};
   endfunction

   // Drive one cycle of inputs and queue the expected outputs for it
   task automatic applyStimulus(input string name, input logic [6:0] in_w,
                                input logic rstn, input logic [18:0] exp);
      expect_t e;
      @(posedge clk);
      #1;
      rst_n = rstn;
      {load_use_stall, branch_taken_ex, mdu_start_ex, mdu_done,
       fault_detected, retire_wb, fault_clear} = in_w;
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
   endtask

   task automatic checkOutput(input expect_t e);
      logic [18:0] act;
      act = actual_word();
      vectors_applied++;
      if (act !== e.exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %05h expected %05h", e.name, act, e.exp);
      end
   endtask

   // Monitor: every cycle presents an output word, compare mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
      end
   end

   initial begin
      logic [18:0] dflt0;
      dflt0 = mk(EN_ALL, FL_NONE, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0);

      applyStimulus("reset_hold", I_NONE, 1'b0,
                    mk(EN_NONE, FL_ALL, 2'b00, 0, 0, 2'b00, 4'd0, 0));
      applyStimulus("idle_a", I_NONE, 1'b1, dflt0);
      applyStimulus("idle_b", I_NONE, 1'b1, dflt0);

      applyStimulus("load_use", I_LU, 1'b1,
                    mk(EN_LU, 3'b010, 2'b00, 0, 0, 2'b00, 4'd0, 0));
      applyStimulus("after_lu", I_NONE, 1'b1, dflt0);

      applyStimulus("mdu_start", I_MS, 1'b1,
                    mk(EN_MDU, 3'b001, 2'b00, 0, 0, 2'b00, 4'd0, 0));
      applyStimulus("mdu_wait1_ign", I_LU | I_BR, 1'b1,
                    mk(EN_MDU, 3'b001, 2'b00, 0, 0, 2'b01, 4'd0, 0));
      for (int i = 2; i <= 3; i++)
         applyStimulus($sformatf("mdu_wait%0d", i), I_NONE, 1'b1,
                       mk(EN_MDU, 3'b001, 2'b00, 0, 0, 2'b01, 4'd0, 0));
      applyStimulus("mdu_release", I_MD, 1'b1,
                    mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'b01, 4'd0, 0));
      applyStimulus("after_mdu", I_NONE, 1'b1, dflt0);

      applyStimulus("mdu_fast", I_MS | I_MD, 1'b1, dflt0);
      applyStimulus("after_fast", I_NONE, 1'b1, dflt0);

      applyStimulus("branch", I_BR, 1'b1,
                    mk(EN_ALL, 3'b110, 2'b01, 0, 0, 2'b00, 4'd0, 0));

      applyStimulus("fault_branch", I_FLT | I_BR, 1'b1,
                    mk(EN_FLT, FL_ALL, 2'b00, 1, 0, 2'b00, 4'd0, 0));
      applyStimulus("replay1_ign", I_FLT | I_BR | I_MS, 1'b1,
                    mk(EN_FLT, FL_ALL, 2'b00, 0, 0, 2'b10, 4'd1, 0));
      applyStimulus("replay_fin", I_NONE, 1'b1,
                    mk(EN_RPFIN, FL_ALL, 2'b10, 0, 0, 2'b10, 4'd1, 0));
      applyStimulus("run_after_rp", I_NONE, 1'b1,
                    mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'b00, 4'd1, 0));
      applyStimulus("retire", I_RET, 1'b1,
                    mk(EN_ALL, FL_NONE, 2'b00, 0, 0, 2'b00, 4'd1, 0));
      applyStimulus("retire_clr", I_NONE, 1'b1, dflt0);

      // Four faults without a clean retire in between
      applyStimulus("fault1_ret", I_FLT | I_RET, 1'b1,
                    mk(EN_FLT, FL_ALL, 2'b00, 1, 0, 2'b00, 4'd0, 0));
      for (int k = 1; k <= 3; k++) begin
         applyStimulus($sformatf("rp%0d_a", k), I_NONE, 1'b1,
                       mk(EN_FLT, FL_ALL, 2'b00, 0, 0, 2'b10, 4'(k), 0));
         applyStimulus($sformatf("rp%0d_fin", k), I_NONE, 1'b1,
                       mk(EN_RPFIN, FL_ALL, 2'b10, 0, 0, 2'b10, 4'(k), 0));
         applyStimulus($sformatf("fault%0d", k + 1), I_FLT, 1'b1,
                       mk(EN_FLT, FL_ALL, 2'b00, 1, 0, 2'b00, 4'(k), 0));
      end
      applyStimulus("halt", I_NONE, 1'b1,
                    mk(EN_NONE, FL_NONE, 2'b00, 0, 0, 2'b11, 4'd3, 1));
      applyStimulus("halt_ign", I_FLT | I_RET | I_BR, 1'b1,
                    mk(EN_NONE, FL_NONE, 2'b00, 0, 0, 2'b11, 4'd3, 1));
      applyStimulus("halt_clear", I_CLR, 1'b1,
                    mk(EN_NONE, FL_NONE, 2'b00, 0, 0, 2'b11, 4'd3, 1));
      applyStimulus("clr_replay", I_NONE, 1'b1,
                    mk(EN_FLT, FL_ALL, 2'b00, 0, 0, 2'b10, 4'd0, 0));
      applyStimulus("clr_rp_fin", I_NONE, 1'b1,
                    mk(EN_RPFIN, FL_ALL, 2'b10, 0, 0, 2'b10, 4'd0, 0));
      applyStimulus("clr_run", I_NONE, 1'b1, dflt0);

      // Fault while waiting on the MDU, then reset in the middle of replay
      applyStimulus("mdu_start2", I_MS, 1'b1,
                    mk(EN_MDU, 3'b001, 2'b00, 0, 0, 2'b00, 4'd0, 0));
      applyStimulus("mdu_fault", I_FLT | I_MD, 1'b1,
                    mk(EN_FLT, FL_ALL, 2'b00, 1, 1, 2'b01, 4'd0, 0));
      applyStimulus("mdu_f_replay", I_NONE, 1'b1,
                    mk(EN_FLT, FL_ALL, 2'b00, 0, 0, 2'b10, 4'd1, 0));
      applyStimulus("reset_in_rp", I_NONE, 1'b0,
                    mk(EN_NONE, FL_ALL, 2'b00, 0, 0, 2'b00, 4'd0, 0));
      applyStimulus("after_reset", I_NONE, 1'b1, dflt0);

      // Let the monitor drain the queue, but never wait forever
      for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(negedge clk);
      @(negedge clk);
      if (sb_q.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d pending, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors_applied, miscompares);
      $finish;
   end

endmodule
